// File: rtl/dm_pkg.sv
// dm_pkg: shared constants and FSM encoding for the data-memory arbiter
package dm_pkg;
    localparam logic WORD = 1'b0;
    localparam logic BYTE = 1'b1;
    localparam int DM_DEPTH = 3072;
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: two requester ports, completion signals and the word-mode memory bus
interface dm_arbiter_if;
    logic req0, req1, we0, we1, mode0, mode1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic ack0, ack1, err, busy;
    logic [31:0] rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic mem_we, mem_mode;
    modport slave (
        input  req0, req1, we0, we1, mode0, mode1, addr0, addr1, wd0, wd1, mem_rd,
        output ack0, ack1, err, busy, rdata, mem_addr, mem_wd, mem_we, mem_mode
    );
    modport master (
        output req0, req1, we0, we1, mode0, mode1, addr0, addr1, wd0, wd1, mem_rd,
        input  ack0, ack1, err, busy, rdata, mem_addr, mem_wd, mem_we, mem_mode
    );
endinterface

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte-lane extraction with sign extension and byte-lane merge
module dm_lane_unit (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  bval,
    output logic [31:0] ext,
    output logic [31:0] merged
);
    logic [7:0] b;
    assign b = word[{lane, 3'b000} +: 8];
    assign ext = {{24{b[7]}}, b};
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[i*8 +: 8] = (lane == 2'(i)) ? bval : word[i*8 +: 8];
    end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU (port 0) and the loader (port 1);
// byte stores are read-modify-write, byte loads are lane-extracted and sign-extended.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW = 12
) (
    input logic clk,
    input logic reset,
    dm_arbiter_if.slave bus
);
    state_t state, next;
    logic op_id, op_we, op_mode, grant, prio, err_c, err_q;
    logic [31:0] op_addr, op_wd, old, rdata_q, ext, merged;

    assign err_c = (op_addr >= 32'(DEPTH * 4)) || (op_mode == WORD && op_addr[1:0] != 2'b00);
    assign grant = (bus.req0 && bus.req1) ? prio : bus.req1;
    assign bus.mem_addr = {op_addr[31:AW+2], op_addr[AW+1:2], 2'b00};
    assign bus.mem_mode = WORD;
    assign bus.busy = state != IDLE;
    assign bus.rdata = rdata_q;
    assign bus.err = err_q;

    // ACCESS extracts from the live read data, MERGE patches the captured old word
    dm_lane_unit u_lane (
        .word(state == MERGE ? old : bus.mem_rd),
        .lane(op_addr[1:0]),
        .bval(op_wd[7:0]),
        .ext(ext),
        .merged(merged)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        bus.mem_we = 1'b0;
        bus.mem_wd = '0;
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        case (state)
            IDLE: next = (bus.req0 || bus.req1) ? ACCESS : IDLE;
            ACCESS: begin
                next = (!err_c && op_we && op_mode == BYTE) ? MERGE : DONE;
                bus.mem_we = !err_c && op_we && op_mode == WORD;
                bus.mem_wd = (!err_c && op_we && op_mode == WORD) ? op_wd : '0;
            end
            MERGE: begin
                next = DONE;
                bus.mem_we = 1'b1;
                bus.mem_wd = merged;
            end
            default: begin
                next = IDLE;
                bus.ack0 = !op_id;
                bus.ack1 = op_id;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_id <= 1'b0;
            op_we <= 1'b0;
            op_mode <= WORD;
            op_addr <= '0;
            op_wd <= '0;
            old <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
            prio <= 1'b0;
        end else begin
            if (state == IDLE && (bus.req0 || bus.req1)) begin
                op_id <= grant;
                op_we <= grant ? bus.we1 : bus.we0;
                op_mode <= grant ? bus.mode1 : bus.mode0;
                op_addr <= grant ? bus.addr1 : bus.addr0;
                op_wd <= grant ? bus.wd1 : bus.wd0;
            end
            if (state == ACCESS) begin
                err_q <= err_c;
                old <= bus.mem_rd;
                rdata_q <= (err_c || op_we) ? '0 : (op_mode == BYTE ? ext : bus.mem_rd);
            end
            if (state == DONE) prio <= !op_id;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized scoreboard bench; a transaction-level model predicts grant order,
// completion cycle, load data and memory writes for every request.
module tb_dm_arbiter;
    import dm_pkg::*;

    typedef struct {
        bit we;
        bit mode;
        logic [31:0] addr;
        logic [31:0] wd;
    } op_t;

    typedef struct {
        bit port;
        bit err;
        bit we;
        bit chk_rd;
        logic [31:0] rdata;
        int ack_cyc;
        int wr_cyc;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit mem_init = 1'b0;
    bit mprio = 1'b0;
    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    exp_t sb[$];
    exp_t mon_e;
    op_t q0[$], q1[$];

    dm_arbiter_if bus();

    dm_arbiter #(.DEPTH(3072), .AW(12)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E3779B9 ^ 32'h5A5A1234;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_we) mem[bus.mem_addr[13:2]] <= bus.mem_wd;
    end
    assign bus.mem_rd = mem[bus.mem_addr[13:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic op_t mk(input bit we, input bit mode, input logic [31:0] addr, input logic [31:0] wd);
        op_t o;
        o.we = we;
        o.mode = mode;
        o.addr = addr;
        o.wd = wd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int r = $urandom_range(0, 9);
        o.we = 1'($urandom);
        o.mode = 1'($urandom);
        o.wd = $urandom;
        o.addr = (r == 0) ? 32'h2FF0 + $urandom_range(0, 31) : (r == 1) ? $urandom : 32'($urandom_range(0, 63));
        if (o.mode == WORD && $urandom_range(0, 3) != 0) o.addr[1:0] = 2'b00;
        return o;
    endfunction

    // Reference: one request at a time against an array image; t is the accept cycle
    function automatic exp_t model(input bit p, input op_t o, input int t);
        exp_t e;
        int w, sh;
        logic [7:0] b;
        w = int'(o.addr >> 2);
        sh = int'(o.addr[1:0]) * 8;
        e.port = p;
        e.we = o.we;
        e.err = (o.addr >= 32'(DM_DEPTH * 4)) || (o.mode == WORD && o.addr[1:0] != 2'b00);
        e.chk_rd = !o.we || e.err;
        e.rdata = '0;
        e.wr_addr = o.addr & ~32'h3;
        e.wr_data = '0;
        e.wr_cyc = -1;
        e.ack_cyc = t + ((o.we && o.mode == BYTE && !e.err) ? 4 : 3) - 1;
        if (!e.err) begin
            if (!o.we) begin
                b = 8'(ref_mem[w] >> sh);
                e.rdata = (o.mode == WORD) ? ref_mem[w] : {{24{b[7]}}, b};
            end else begin
                e.wr_data = (o.mode == WORD) ? o.wd : (ref_mem[w] & ~(32'hFF << sh)) | ({24'b0, o.wd[7:0]} << sh);
                ref_mem[w] = e.wr_data;
                e.wr_cyc = t + ((o.mode == BYTE) ? 2 : 1);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (sb.size() == 0 || !sb[0].we || sb[0].err) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_write: mem_we=1 addr %h data %h, expected no write", bus.mem_addr, bus.mem_wd);
            end else begin
                chk("wr_addr", bus.mem_addr, sb[0].wr_addr);
                chk("wr_data", bus.mem_wd, sb[0].wr_data);
                chk("wr_cycle", 32'(cyc), 32'(sb[0].wr_cyc));
            end
        end
        if (bus.ack0 || bus.ack1) begin
            if (sb.size() == 0 || (bus.ack0 && bus.ack1)) begin
                n_checks++;
                n_errors++;
                $display("FAIL ack: ack0=%b ack1=%b with %0d outstanding, expected single expected ack", bus.ack0, bus.ack1, sb.size());
            end else begin
                mon_e = sb.pop_front();
                chk("ack_port", 32'(bus.ack1), 32'(mon_e.port));
                chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                chk("err", 32'(bus.err), 32'(mon_e.err));
                if (mon_e.chk_rd) chk("rdata", bus.rdata, mon_e.rdata);
            end
        end
    end

    task automatic drive(input bit p, input bit r, input op_t o);
        if (p) begin
            bus.req1 = r; bus.we1 = o.we; bus.mode1 = o.mode; bus.addr1 = o.addr; bus.wd1 = o.wd;
        end else begin
            bus.req0 = r; bus.we0 = o.we; bus.mode0 = o.mode; bus.addr0 = o.addr; bus.wd0 = o.wd;
        end
    endtask

    task automatic present(input bit p);
        if (p) begin
            if (q1.size() > 0) drive(1'b1, 1'b1, q1[0]);
            else drive(1'b1, 1'b0, rand_op());
        end else begin
            if (q0.size() > 0) drive(1'b0, 1'b1, q0[0]);
            else drive(1'b0, 1'b0, rand_op());
        end
    endtask

    // Each port keeps its req high while it has queued ops; the next op appears in its ack cycle
    task automatic run_batch(input bit hold_rst);
        op_t c0[$], c1[$];
        int t, guard, i0, i1;
        bit p;
        @(negedge clk);
        c0 = q0;
        c1 = q1;
        present(1'b0);
        present(1'b1);
        if (hold_rst) begin
            @(negedge clk);
            reset = 1'b1;
        end
        t = cyc;
        i0 = 0;
        i1 = 0;
        while (i0 < c0.size() || i1 < c1.size()) begin
            p = (i0 < c0.size() && i1 < c1.size()) ? mprio : (i1 < c1.size());
            if (p) begin
                sb.push_back(model(1'b1, c1[i1], t));
                i1++;
            end else begin
                sb.push_back(model(1'b0, c0[i0], t));
                i0++;
            end
            t = sb[$].ack_cyc + 1;
            mprio = !p;
        end
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 400) begin
            @(negedge clk);
            guard++;
            if (bus.ack0 && q0.size() > 0) begin
                void'(q0.pop_front());
                present(1'b0);
            end
            if (bus.ack1 && q1.size() > 0) begin
                void'(q1.pop_front());
                present(1'b1);
            end
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL batch_timeout: %0d ops still pending, expected 0", q0.size() + q1.size());
            q0.delete();
            q1.delete();
            sb.delete();
            drive(1'b0, 1'b0, rand_op());
            drive(1'b1, 1'b0, rand_op());
        end
    endtask

    initial begin
        int bad, n0, n1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        drive(1'b0, 1'b0, mk(0, WORD, 0, 0));
        drive(1'b1, 1'b0, mk(0, WORD, 0, 0));
        #1 reset = 1'b0;
        #2;
        chk("rst_ack0", 32'(bus.ack0), 0);
        chk("rst_ack1", 32'(bus.ack1), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wd", bus.mem_wd, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mem_mode", 32'(bus.mem_mode), 0);

        // contention from reset, word store/load path on both ports
        q0 = '{mk(1, WORD, 32'h10, 32'h12345678), mk(0, WORD, 32'h10, 0)};
        q1 = '{mk(1, WORD, 32'h40, 32'hCAFEF00D), mk(0, WORD, 32'h40, 0)};
        run_batch(1'b1);

        q0 = '{mk(1, WORD, 32'h10, 32'hAABBCCDD)};
        run_batch(1'b0);
        q1 = '{mk(1, BYTE, 32'h12, 32'h5E)};
        run_batch(1'b0);
        chk("byte_merge_mem", mem[4], 32'hAA5ECCDD);
        q0 = '{mk(0, WORD, 32'h10, 0)};
        run_batch(1'b0);

        q1 = '{mk(1, WORD, 32'h10, 32'h80000000), mk(0, BYTE, 32'h13, 0),
               mk(1, WORD, 32'h10, 32'h0000007F), mk(0, BYTE, 32'h10, 0)};
        run_batch(1'b0);

        q0 = '{mk(0, WORD, 32'h3000, 0), mk(1, WORD, 32'h6, 32'hDEADBEEF), mk(0, BYTE, 32'h2FFF, 0),
               mk(0, WORD, 32'h2FFC, 0), mk(1, BYTE, 32'h3001, 32'h11)};
        run_batch(1'b0);
        chk("err_word1_kept", mem[1], init_val(1));

        // reset during MERGE of a byte store to 0x20
        @(negedge clk);
        drive(1'b0, 1'b1, mk(1, BYTE, 32'h20, 32'h77));
        @(posedge clk);
        @(posedge clk);
        #1 chk("abort_we_in_merge", 32'(bus.mem_we), 1);
        chk("abort_addr", bus.mem_addr, 32'h20);
        #1 reset = 1'b0;
        drive(1'b0, 1'b0, rand_op());
        #1 chk("abort_we_drop", 32'(bus.mem_we), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        chk("abort_mem_kept", mem[8], ref_mem[8]);
        chk("abort_no_ack", 32'(bus.ack0), 0);
        reset = 1'b1;
        mprio = 1'b0;
        q0 = '{mk(0, WORD, 32'h10, 0), mk(1, BYTE, 32'h21, 32'h99), mk(0, WORD, 32'h20, 0)};
        run_batch(1'b0);

        for (int b = 0; b < 12; b++) begin
            n0 = $urandom_range(0, 4);
            n1 = (n0 == 0) ? $urandom_range(1, 4) : $urandom_range(0, 4);
            for (int i = 0; i < n0; i++) q0.push_back(rand_op());
            for (int i = 0; i < n1; i++) q1.push_back(rand_op());
            run_batch(1'b0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image_bad_words", 32'(bad), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
